// File: rtl/kersram_wr_ctrl_if.sv
// FIFO-side and SRAM-side signal bundle of the kernel-SRAM write controller.
interface kersram_wr_ctrl_if #(
    parameter int NUM_BANKS = 8,
    parameter int DATA_W    = 64,
    parameter int ADDR_BITS = 10
);
    logic [DATA_W-1:0]              fifo_data;
    logic                           fifo_empty_n;
    logic                           fifo_read;
    logic [NUM_BANKS-1:0]           sram_cen;
    logic [NUM_BANKS-1:0]           sram_wen;
    logic [NUM_BANKS*ADDR_BITS-1:0] sram_addr;
    logic [NUM_BANKS*DATA_W-1:0]    sram_din;

    modport master (
        input  fifo_data, fifo_empty_n,
        output fifo_read, sram_cen, sram_wen, sram_addr, sram_din
    );

    modport slave (
        output fifo_data, fifo_empty_n,
        input  fifo_read, sram_cen, sram_wen, sram_addr, sram_din
    );
endinterface

// File: rtl/kersram_wr_ctrl.sv
// Kernel-SRAM write controller: drains a kernel FIFO and scatters cfg_len words
// into each of cfg_banks SRAM banks, either all in the pop cycle or skewed per bank.
module kersram_wr_ctrl #(
    parameter int NUM_BANKS = 8,
    parameter int DATA_W    = 64,
    parameter int ADDR_BITS = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_BITS:0] cfg_len,
    input  logic [4:0]         cfg_banks,
    input  logic               cfg_skew,
    kersram_wr_ctrl_if.master  bus,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    typedef struct packed {
        logic                 vld;
        logic [BW-1:0]        bank;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_W-1:0]    data;
    } stage_t;

    state_t               state;
    logic [ADDR_BITS-1:0] len_m1;
    logic [ADDR_BITS-1:0] addr_cnt;
    logic [BW-1:0]        banks_m1;
    logic [BW-1:0]        bank_idx;
    logic [BW-1:0]        drain_cnt;
    logic                 skew_q;
    logic                 pop;
    logic                 cfg_bad;
    stage_t               live;
    stage_t               dline [NUM_BANKS-1];
    stage_t               tap   [NUM_BANKS];

    assign pop           = (state == FILL) && bus.fifo_empty_n;
    assign bus.fifo_read = pop;
    assign cfg_bad       = (cfg_len == '0) || (cfg_banks == '0) || (cfg_banks > 5'(NUM_BANKS));
    assign live          = '{vld: pop, bank: bank_idx, addr: addr_cnt, data: bus.fifo_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            len_m1    <= '0;
            banks_m1  <= '0;
            skew_q    <= 1'b0;
            addr_cnt  <= '0;
            bank_idx  <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    busy <= 1'b1;
                    if (cfg_bad) begin
                        cfg_err <= 1'b1;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cfg_err  <= 1'b0;
                        len_m1   <= ADDR_BITS'(cfg_len - 1'b1);
                        banks_m1 <= BW'(cfg_banks - 5'd1);
                        skew_q   <= cfg_skew;
                        addr_cnt <= '0;
                        bank_idx <= '0;
                        state    <= FILL;
                    end
                end
                FILL: if (pop) begin
                    if (addr_cnt == len_m1) begin
                        addr_cnt <= '0;
                        if (bank_idx == banks_m1) begin
                            bank_idx  <= '0;
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end else begin
                            bank_idx <= bank_idx + 1'b1;
                        end
                    end else begin
                        addr_cnt <= addr_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == (skew_q ? banks_m1 : '0)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Only skewed jobs load valid entries, so a direct job never leaves stale
    // writes in the line for a following skewed job.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned j = 0; j < NUM_BANKS - 1; j++) dline[j] <= '0;
        end else begin
            dline[0] <= '{vld: pop & skew_q, bank: bank_idx, addr: addr_cnt, data: bus.fifo_data};
            for (int unsigned j = 1; j < NUM_BANKS - 1; j++) dline[j] <= dline[j-1];
        end
    end

    assign tap[0] = live;
    for (genvar k = 1; k < NUM_BANKS; k++) begin : g_tap
        assign tap[k] = dline[k-1];
    end

    always_comb begin
        stage_t src;
        src           = '0;
        bus.sram_cen  = '1;
        bus.sram_addr = '0;
        bus.sram_din  = '0;
        for (int unsigned k = 0; k < NUM_BANKS; k++) begin
            src = skew_q ? tap[k] : live;
            if (src.vld && (src.bank == BW'(k))) begin
                bus.sram_cen[k] = 1'b0;
                bus.sram_addr[k*ADDR_BITS +: ADDR_BITS] = src.addr;
            end
            bus.sram_din[k*DATA_W +: DATA_W] = src.data;
        end
    end

    assign bus.sram_wen = bus.sram_cen;
endmodule

// File: tb/tb_kersram_wr_ctrl.sv
// Self-checking bench for kersram_wr_ctrl: job table plus reset and busy-start
// sequences, with a per-bank write scoreboard fed from a bench-side FIFO model.
module tb_kersram_wr_ctrl;
    localparam int NB = 8;
    localparam int DW = 64;
    localparam int AB = 10;
    localparam int LW = AB + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AB:0]   cfg_len = '0;
    logic [4:0]    cfg_banks = '0;
    logic          cfg_skew = 1'b0;
    logic          busy, done, cfg_err;

    kersram_wr_ctrl_if #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_BITS(AB)) bus ();

    kersram_wr_ctrl #(.NUM_BANKS(NB), .DATA_W(DW), .ADDR_BITS(AB)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .cfg_len  (cfg_len),
        .cfg_banks(cfg_banks),
        .cfg_skew (cfg_skew),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AB-1:0] addr;
        logic [DW-1:0] data;
        int            due;
    } wr_t;

    typedef struct {
        bit skew;
        int len;
        int banks;
        bit bubble;
        bit err;
        int pops;
        int lat;
    } vec_t;

    wr_t  exp_q [NB][$];
    vec_t vt [13];

    int total = 0, bad = 0, cyc = 0;
    bit mon_en = 0, fill_on = 0, job_on = 0, exp_err = 0, bubbly = 0, cur_skew = 0;
    int pop_idx = 0, obs_pops = 0, job_id = 0, cur_len = 1, cur_banks = 1, cur_lat = 0;
    int done_due = -1;

    function automatic logic [DW-1:0] mkword(input int j, input int i);
        return {8'hA5, 24'(j), 32'(i)};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle-level expectations: pops, per-bank writes, busy, done, cfg_err.
    task automatic monitor();
        bit  exp_rd, we;
        int  b;
        wr_t w;
        exp_rd = fill_on && bus.fifo_empty_n;
        chk("fifo_read", 64'(bus.fifo_read), 64'(exp_rd));
        if (bus.fifo_read) obs_pops++;
        if (exp_rd) begin
            b      = pop_idx / cur_len;
            w.addr = AB'(pop_idx % cur_len);
            w.data = mkword(job_id, pop_idx);
            w.due  = cyc + (cur_skew ? b : 0);
            exp_q[b].push_back(w);
            pop_idx++;
            if (pop_idx == cur_len * cur_banks) begin
                fill_on  = 0;
                done_due = cyc + cur_lat;
            end
        end
        for (int k = 0; k < NB; k++) begin
            we = (exp_q[k].size() > 0) && (exp_q[k][0].due == cyc);
            chk($sformatf("cen[%0d]", k), 64'(bus.sram_cen[k]), 64'(!we));
            chk($sformatf("wen[%0d]", k), 64'(bus.sram_wen[k]), 64'(!we));
            if (we) begin
                w = exp_q[k].pop_front();
                chk($sformatf("addr[%0d]", k), 64'(bus.sram_addr[k*AB +: AB]), 64'(w.addr));
                chk($sformatf("din[%0d]", k), bus.sram_din[k*DW +: DW], w.data);
            end else begin
                chk($sformatf("idle_addr[%0d]", k), 64'(bus.sram_addr[k*AB +: AB]), 64'(0));
            end
        end
        chk("busy", 64'(busy), 64'(job_on));
        chk("done", 64'(done), 64'(job_on && (cyc == done_due)));
        chk("cfg_err", 64'(cfg_err), 64'(exp_err));
        if (job_on && (cyc == done_due)) job_on = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        if (mon_en) monitor();
        @(posedge clk);
        cyc++;
        #1;
        bus.fifo_data    = mkword(job_id, pop_idx);
        bus.fifo_empty_n = bubbly ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic begin_job(input vec_t v, input int id);
        int t0;
        t0        = cyc;
        start     = 1'b1;
        cfg_len   = LW'(v.len);
        cfg_banks = 5'(v.banks);
        cfg_skew  = v.skew;
        job_id    = id;
        pop_idx   = 0;
        obs_pops  = 0;
        bubbly    = v.bubble;
        cur_len   = v.len;
        cur_banks = v.banks;
        cur_skew  = v.skew;
        cur_lat   = v.lat;
        tick();
        start   = 1'b0;
        exp_err = v.err;
        job_on  = 1;
        if (v.err) begin
            done_due = t0 + v.lat;
        end else begin
            fill_on  = 1;
            done_due = -1;
        end
    endtask

    task automatic wait_job(input string name, input int budget);
        int n;
        n = 0;
        while (job_on && (n < budget)) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, 64'(job_on), 64'(0));
        job_on  = 0;
        fill_on = 0;
    endtask

    task automatic end_checks(input string name, input vec_t v);
        chk({name, "_pops"}, 64'(obs_pops), 64'(v.pops));
        chk({name, "_err_held"}, 64'(cfg_err), 64'(v.err));
        for (int k = 0; k < NB; k++)
            chk($sformatf("%s_leftover[%0d]", name, k), 64'(exp_q[k].size()), 64'(0));
    endtask

    initial begin
        //          skew len   banks bub err pops  lat
        vt[0]  = '{0,   4,    8,    0,  0,  32,   2};
        vt[1]  = '{1,   4,    8,    0,  0,  32,   9};
        vt[2]  = '{1,   3,    1,    0,  0,  3,    2};
        vt[3]  = '{0,   288,  8,    1,  0,  2304, 2};
        vt[4]  = '{0,   1024, 3,    0,  0,  3072, 2};
        vt[5]  = '{0,   0,    8,    0,  1,  0,    1};
        vt[6]  = '{0,   4,    9,    0,  1,  0,    1};
        vt[7]  = '{0,   2,    2,    0,  0,  4,    2};
        vt[8]  = '{1,   4,    0,    0,  1,  0,    1};
        vt[9]  = '{1,   5,    3,    1,  0,  15,   4};
        vt[10] = '{1,   1,    8,    0,  0,  8,    9};
        vt[11] = '{1,   6,    8,    1,  0,  48,   9};
        vt[12] = '{0,   7,    5,    1,  0,  35,   2};

        bus.fifo_data    = '0;
        bus.fifo_empty_n = 1'b1;
        reset = 1'b1;
        repeat (3) tick();
        #1;
        chk("rst_fifo_read", 64'(bus.fifo_read), 64'(0));
        chk("rst_cen", 64'(bus.sram_cen), 64'(8'hFF));
        chk("rst_wen", 64'(bus.sram_wen), 64'(8'hFF));
        chk("rst_addr", 64'(bus.sram_addr[63:0]), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_cfg_err", 64'(cfg_err), 64'(0));
        reset  = 1'b0;
        mon_en = 1;
        repeat (2) tick();

        for (int i = 0; i < 13; i++) begin
            begin_job(vt[i], i + 1);
            wait_job($sformatf("vec%0d", i), vt[i].pops * 4 + 60);
            end_checks($sformatf("vec%0d", i), vt[i]);
        end

        // Reset in the middle of a skewed fill: nothing may be written afterwards.
        begin_job('{1, 8, 8, 0, 0, 64, 9}, 100);
        repeat (20) tick();
        mon_en = 0;
        reset  = 1'b1;
        tick();
        fill_on  = 0;
        job_on   = 0;
        exp_err  = 0;
        done_due = -1;
        for (int k = 0; k < NB; k++) exp_q[k].delete();
        mon_en = 1;
        tick();
        reset = 1'b0;
        repeat (12) tick();

        // Fresh job with start pulses (bad config) while it is busy.
        begin_job('{1, 2, 2, 0, 0, 4, 3}, 101);
        tick();
        start = 1'b1; cfg_len = '0; cfg_banks = 5'd1; cfg_skew = 1'b0;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; cfg_len = LW'(5); cfg_banks = 5'd7;
        tick();
        start = 1'b0;
        wait_job("busy_start", 60);
        end_checks("busy_start", '{1, 2, 2, 0, 0, 4, 3});
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/kersram_wr_ctrl.md
# kersram_wr_ctrl

Parametrised kernel-SRAM write controller: drains a FIFO of kernel words and scatters them bank-by-bank into `NUM_BANKS` single-port SRAMs, `cfg_len` words per bank. Successor of the fixed 8-bank, fixed-length kernel writer. Adds runtime length and bank count, configuration error detection, and two selectable write modes: direct, where all banks are written in the pop cycle, and skewed, where bank k is written k cycles after the pop. Sits between the kernel DMA FIFO and the kernel SRAM array in the kernel load path.

## Interface
Parameters:
- `NUM_BANKS`, 8, number of kernel SRAM banks (2..16)
- `DATA_W`, 64, FIFO/SRAM word width
- `ADDR_BITS`, 10, SRAM address width

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle request; ignored unless idle
- `cfg_len`  in  ADDR_BITS+1  words per bank, 1..2^ADDR_BITS; latched at start
- `cfg_banks`  in  5  banks to fill, 1..NUM_BANKS; latched at start
- `cfg_skew`  in  1  0 = direct mode, 1 = skewed mode; latched at start
- `fifo_data`  in  DATA_W  FIFO head word
- `fifo_empty_n`  in  1  FIFO holds data
- `fifo_read`  out  1  pop strobe
- `sram_cen`  out  NUM_BANKS  per-bank chip enable, active-low
- `sram_wen`  out  NUM_BANKS  per-bank write enable, active-low; always equal to `sram_cen`
- `sram_addr`  out  NUM_BANKS*ADDR_BITS  bank k occupies bits [k*ADDR_BITS +: ADDR_BITS]
- `sram_din`  out  NUM_BANKS*DATA_W  bank k occupies bits [k*DATA_W +: DATA_W]
- `busy`  out  1  high in FILL, DRAIN and DONE
- `done`  out  1  one-cycle completion pulse
- `cfg_err`  out  1  last start carried an illegal configuration; held until the next accepted start

## Operation
- FSM states: IDLE, FILL, DRAIN, DONE.
- IDLE:
  - On `start` with a legal configuration, go to FILL.
  - On `start` with `cfg_len`==0, `cfg_banks`==0 or `cfg_banks`>NUM_BANKS, set `cfg_err` and go directly to DONE. No FIFO pops occur.
- FILL:
  - `fifo_read` = `fifo_empty_n` (combinational); pop = `fifo_read`.
  - Each pop carries (bank_idx, addr_cnt, `fifo_data`), then increments addr_cnt.
  - When addr_cnt = len-1: addr_cnt wraps to 0 and bank_idx increments.
  - A pop with bank_idx = banks-1 and addr_cnt = len-1 moves the FSM to DRAIN.
- DRAIN: drain_cnt starts at 0 and increments each cycle. Exit to DONE when drain_cnt = (skew ? banks-1 : 0).
- DONE: `done`=1 for one cycle, then IDLE.
- Direct mode: the bank k write fires in the pop cycle when bank_idx==k, with addr = addr_cnt and din = `fifo_data`.
- Skewed mode: a delay line of NUM_BANKS-1 stages, each holding {valid, bank, addr, data}. Stage 0 is the live pop. Bank k writes when stage k is valid and stage k bank==k. Its addr and din come from stage k.
- Idle outputs: a bank that is not writing drives cen=wen=1 and addr=0. Its din is don't-care; drive stage/FIFO data without gating.
- Each bank is written exactly `cfg_len` times per job, at addresses 0..len-1 in order. Banks ≥ `cfg_banks` are never written.

## Timing
- Reset values: `fifo_read`=0, `sram_cen`=`sram_wen`=all 1, `sram_addr`=0, `busy`=0, `done`=0, `cfg_err`=0. FSM goes to IDLE, counters go to 0, delay-line valids are cleared.
- `start` in cycle T → FILL at T+1; the first pop is possible at T+1.
- Last pop at cycle P:
  - Direct mode: DRAIN at P+1, `done` at P+2.
  - Skewed mode: last write at P+banks-1, `done` at P+banks+1.
- Illegal configuration: `start` at T → `done` and `cfg_err` both visible at T+1.
- FIFO empty mid-FILL: no pop and no write. Counters hold. No timeout.
- `start` while busy: ignored, with no effect on the latched config.
- `reset` mid-job: all writes are abandoned the next cycle and in-flight skewed writes are discarded. The SRAM contents are undefined for that job.
- Boundaries:
  - `cfg_len`=2^ADDR_BITS: addr_cnt reaches all-ones, then wraps.
  - `cfg_banks`=1 in skewed mode behaves identically to direct mode.

## Test plan
- Direct, NUM_BANKS=8, len=4, banks=8, FIFO always full, data=0..31 → `fifo_read` high for 32 cycles. Bank k gets data 4k..4k+3 at addr 0..3. `done` arrives 2 cycles after the last pop.
- Skewed, same stimulus → bank 3 first writes 3 cycles after word 12 pops. No two banks write the same cycle with identical stage data. `done` arrives 9 cycles after the last pop.
- Bubbly FIFO (`fifo_empty_n` random 50%), len=288, banks=8 → all 2304 words land in the correct bank and address. No write occurs in an empty cycle.
- `cfg_banks`=3, len=1024 → only banks 0..2 are written. The address wraps 1023→0 at each bank change. `sram_cen[7:3]` stays all 1.
- Illegal configs: `cfg_len`=0, then `cfg_banks`=9 → `done` and `cfg_err` one cycle after `start`, zero pops. A following legal start clears `cfg_err`.
- Reset asserted mid-FILL in skewed mode, then a new job with len=2, banks=2 → no stale writes after reset. The new job completes normally and `start` pulses issued during busy are ignored.
